rs_decode_ctrl: RTL

RS_DECODE_CTRL -- requirements
Module: rs_decode_ctrl

---
 rtl/rs_decode_ctrl.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/rs_decode_ctrl.sv
// ---------------------------------------------------------------------------
// rs_decode_ctrl
// Frame-level sequencer for a Reed-Solomon decoder. Walks each frame through
// syndrome calculation, Berlekamp-Massey, the Chien/Forney latency, and the
// N-symbol correction window. It counts Chien roots and flags decode failure.
//
// Parameters
//   N          symbols per frame
//   T          maximum correctable errors
//   FORNEY_LAT cycles from the BM_done cycle to the first corr_en cycle
//
// Ports
//   clk_in          clock, rising edge
//   rst_in          synchronous active-high reset
//   frame_valid_in  first-symbol strobe of a new frame
//   Scalc_done      syndrome calculation complete pulse
//   BM_done         Berlekamp-Massey complete pulse
//   deg_lambda      degree of Lambda(x), valid with BM_done
//   err_found       Chien root for the current corr_en symbol
//   in_ready        controller idle, frame_valid_in will be accepted
//   BM_start        one-cycle start pulse to BM
//   chien_start     one-cycle start pulse to Chien/Forney
//   corr_en         correction window
//   sym_idx         symbol index inside the correction window
//   err_cnt         roots found this frame (saturates at 15)
//   frame_done      one-cycle end-of-frame pulse
//   fail            decode failure, valid with frame_done, held afterwards
//   ovf             sticky: a frame strobe arrived while busy
// ---------------------------------------------------------------------------
module rs_decode_ctrl #(
   parameter int N          = 255,
   parameter int T          = 8,
   parameter int FORNEY_LAT = 14
) (
   input  logic       clk_in,
   input  logic       rst_in,
   input  logic       frame_valid_in,
   input  logic       Scalc_done,
   input  logic       BM_done,
   input  logic [3:0] deg_lambda,
   input  logic       err_found,
   output logic       in_ready,
   output logic       BM_start,
   output logic       chien_start,
   output logic       corr_en,
   output logic [7:0] sym_idx,
   output logic [3:0] err_cnt,
   output logic       frame_done,
   output logic       fail,
   output logic       ovf
);

   localparam int LAT_W = (FORNEY_LAT > 1) ? $clog2(FORNEY_LAT) : 1;
   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(FORNEY_LAT - 1);
   localparam logic [7:0]       SYM_LAST = 8'(N - 1);

   typedef enum logic [2:0] {IDLE, SYND, BM, WAIT_F, CORR, DONE} state_t;

   state_t           state, state_nxt;
   logic [LAT_W-1:0] lat_cnt, lat_nxt;
   logic [3:0]       deg_q, deg_nxt;
   logic             in_ready_nxt, bm_start_nxt, chien_start_nxt, corr_en_nxt;
   logic             frame_done_nxt, fail_nxt, ovf_nxt;
   logic [7:0]       sym_idx_nxt;
   logic [3:0]       err_cnt_nxt;

   function automatic logic [3:0] sat_inc(input logic [3:0] v);
      return (v == 4'hF) ? v : v + 4'd1;
   endfunction

   function automatic logic decode_fail(input logic [3:0] cnt, input logic [3:0] deg);
      return (cnt != deg) || (int'(deg) > T);
   endfunction

   always_comb begin
      state_nxt       = state;
      lat_nxt         = lat_cnt;
      deg_nxt         = deg_q;
      in_ready_nxt    = 1'b0;
      bm_start_nxt    = 1'b0;
      chien_start_nxt = 1'b0;
      corr_en_nxt     = 1'b0;
      frame_done_nxt  = 1'b0;
      sym_idx_nxt     = sym_idx;
      err_cnt_nxt     = err_cnt;
      fail_nxt        = fail;
      // A strobe while busy is only recorded, never acted on.
      ovf_nxt         = ovf | (frame_valid_in & ~in_ready);

      case (state)
         IDLE: begin
            in_ready_nxt = 1'b1;
            if (frame_valid_in) begin
               state_nxt    = SYND;
               in_ready_nxt = 1'b0;
            end
         end
         SYND: begin
            if (Scalc_done) begin
               state_nxt    = BM;
               bm_start_nxt = 1'b1;
            end
         end
         BM: begin
            if (BM_done) begin
               deg_nxt         = deg_lambda;
               err_cnt_nxt     = 4'd0;
               fail_nxt        = 1'b0;
               lat_nxt         = LAT_LOAD;
               chien_start_nxt = 1'b1;
               // With a single-cycle latency the window opens right away.
               if (FORNEY_LAT <= 1) begin
                  state_nxt   = CORR;
                  corr_en_nxt = 1'b1;
                  sym_idx_nxt = 8'd0;
               end else begin
                  state_nxt = WAIT_F;
               end
            end
         end
         WAIT_F: begin
            // Leaving at count 1 makes corr_en register high exactly
            // FORNEY_LAT cycles after the BM_done cycle.
            if (lat_cnt <= LAT_W'(1)) begin
               state_nxt   = CORR;
               lat_nxt     = '0;
               corr_en_nxt = 1'b1;
               sym_idx_nxt = 8'd0;
            end else begin
               lat_nxt = lat_cnt - LAT_W'(1);
            end
         end
         CORR: begin
            if (err_found)
               err_cnt_nxt = sat_inc(err_cnt);
            if (sym_idx == SYM_LAST) begin
               state_nxt      = DONE;
               frame_done_nxt = 1'b1;
               fail_nxt       = decode_fail(err_cnt_nxt, deg_q);
            end else begin
               corr_en_nxt = 1'b1;
               sym_idx_nxt = sym_idx + 8'd1;
            end
         end
         DONE: begin
            state_nxt    = IDLE;
            in_ready_nxt = 1'b1;
         end
         default: begin
            state_nxt    = IDLE;
            in_ready_nxt = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         in_ready    <= 1'b1;
         BM_start    <= 1'b0;
         chien_start <= 1'b0;
         corr_en     <= 1'b0;
         sym_idx     <= 8'd0;
         err_cnt     <= 4'd0;
         frame_done  <= 1'b0;
         fail        <= 1'b0;
         ovf         <= 1'b0;
      end else begin
         state       <= state_nxt;
         lat_cnt     <= lat_nxt;
         in_ready    <= in_ready_nxt;
         BM_start    <= bm_start_nxt;
         chien_start <= chien_start_nxt;
         corr_en     <= corr_en_nxt;
         sym_idx     <= sym_idx_nxt;
         err_cnt     <= err_cnt_nxt;
         frame_done  <= frame_done_nxt;
         fail        <= fail_nxt;
         ovf         <= ovf_nxt;
      end
   end

   // Latched degree is data only; it is always rewritten before use.
   always_ff @(posedge clk_in) begin
      deg_q <= deg_nxt;
   end

endmodule
